// File: rtl/int_wb_scoreboard_if.sv
// Bundle of decode, result-source and register-file write-port signals for
// the integer writeback scoreboard. The master side drives decode and results.
interface int_wb_scoreboard_if #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int QDEPTH = 4
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic            issue_valid;
  logic            issue_fpu;
  logic [AW-1:0]   issue_rd;
  logic            rs1_en;
  logic            rs2_en;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            stall;

  logic            csr_valid;
  logic [AW-1:0]   csr_rd;
  logic [XLEN-1:0] csr_data;

  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            fpu_valid;
  logic [AW-1:0]   fpu_rd;
  logic [XLEN-1:0] fpu_data;
  logic            fpu_ready;

  logic            wb_wen;
  logic [AW-1:0]   wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  logic [CW-1:0]   fifo_count;
  logic            busy;

  modport master (
    output issue_valid, issue_fpu, issue_rd, rs1_en, rs2_en, rs1_addr, rs2_addr,
    output csr_valid, csr_rd, csr_data,
    output alu_valid, alu_rd, alu_data,
    output fpu_valid, fpu_rd, fpu_data,
    input  stall, alu_ready, fpu_ready,
    input  wb_wen, wb_waddr, wb_wdata, fifo_count, busy
  );

  modport slave (
    input  issue_valid, issue_fpu, issue_rd, rs1_en, rs2_en, rs1_addr, rs2_addr,
    input  csr_valid, csr_rd, csr_data,
    input  alu_valid, alu_rd, alu_data,
    input  fpu_valid, fpu_rd, fpu_data,
    output stall, alu_ready, fpu_ready,
    output wb_wen, wb_waddr, wb_wdata, fifo_count, busy
  );
endinterface

// File: rtl/int_wb_scoreboard.sv
// Integer writeback arbiter (CSR > ALU > FPU FIFO head, with anti-starvation)
// plus a pending-destination scoreboard that stalls RAW/WAW hazards at decode.
module int_wb_scoreboard #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst_l,
  int_wb_scoreboard_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [NREG-1:0] pend_q, pend_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            wbWen_q, wbWen_d;
  logic [AW-1:0]   wbWaddr_q, wbWaddr_d;
  logic [XLEN-1:0] wbWdata_q, wbWdata_d;

  logic [XLEN-1:0] fifoData_q [QDEPTH];
  logic [AW-1:0]   fifoRd_q   [QDEPTH];

  logic            headValid;
  logic            starveHi;
  logic            fpuReady;
  logic            push;
  logic            grantCsr;
  logic            grantAlu;
  logic            grantFifo;
  logic            stallInt;
  logic [AW-1:0]   headRd;
  logic [XLEN-1:0] headData;
  logic [AW-1:0]   selRd;
  logic [XLEN-1:0] selData;

  assign headValid = (count_q != '0);
  assign starveHi  = (starve_q == SW'(STARVE_MAX));
  assign headRd    = fifoRd_q[rdPtr_q];
  assign headData  = fifoData_q[rdPtr_q];

  // Outputs seen by neighbours are forced low while reset is held.
  assign fpuReady  = rst_l & (count_q != CW'(QDEPTH));
  assign push      = bus.fpu_valid & fpuReady;

  assign grantCsr  = bus.csr_valid;
  assign grantFifo = ~bus.csr_valid & headValid & (starveHi | ~bus.alu_valid);
  assign grantAlu  = ~bus.csr_valid & bus.alu_valid & ~grantFifo;

  assign stallInt  = rst_l & bus.issue_valid &
                     ((bus.rs1_en & pend_q[bus.rs1_addr]) |
                      (bus.rs2_en & pend_q[bus.rs2_addr]) |
                      pend_q[bus.issue_rd]);

  always_comb begin
    selRd   = '0;
    selData = '0;
    if (grantCsr) begin
      selRd   = bus.csr_rd;
      selData = bus.csr_data;
    end else if (grantAlu) begin
      selRd   = bus.alu_rd;
      selData = bus.alu_data;
    end else if (grantFifo) begin
      selRd   = headRd;
      selData = headData;
    end
  end

  // x0 results are consumed like any other but never reach the register file.
  always_comb begin
    wbWen_d   = (grantCsr | grantAlu | grantFifo) & (selRd != '0);
    wbWaddr_d = wbWen_d ? selRd : '0;
    wbWdata_d = wbWen_d ? selData : '0;
  end

  // Clear before set so an issue to the same register in the same cycle wins.
  always_comb begin
    pend_d = pend_q;
    if (grantFifo) begin
      pend_d[headRd] = 1'b0;
    end
    if (bus.issue_valid & bus.issue_fpu & ~stallInt & (bus.issue_rd != '0)) begin
      pend_d[bus.issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    wrPtr_d = wrPtr_q + PW'(push);
    rdPtr_d = rdPtr_q + PW'(grantFifo);
    count_d = count_q + CW'(push) - CW'(grantFifo);
    if (~headValid | grantFifo) begin
      starve_d = '0;
    end else if (~starveHi) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend_q    <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      wbWen_q   <= 1'b0;
      wbWaddr_q <= '0;
      wbWdata_q <= '0;
    end else begin
      pend_q    <= pend_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      wbWen_q   <= wbWen_d;
      wbWaddr_q <= wbWaddr_d;
      wbWdata_q <= wbWdata_d;
    end
  end

  // Storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoData_q[wrPtr_q] <= bus.fpu_data;
      fifoRd_q[wrPtr_q]   <= bus.fpu_rd;
    end
  end

  assign bus.stall      = stallInt;
  assign bus.alu_ready  = rst_l & grantAlu;
  assign bus.fpu_ready  = fpuReady;
  assign bus.wb_wen     = wbWen_q;
  assign bus.wb_waddr   = wbWaddr_q;
  assign bus.wb_wdata   = wbWdata_q;
  assign bus.fifo_count = count_q;
  assign bus.busy       = |pend_q;

endmodule

// File: tb/tb_int_wb_scoreboard.sv
// Directed bench for int_wb_scoreboard: a vector table for single-cycle
// behaviour plus hand sequences for starvation, FIFO full/wrap and reset.
module tb_int_wb_scoreboard;

  typedef struct {
    logic [31:0] issueValid, issueFpu, issueRd;
    logic [31:0] rs1En, rs1Addr, rs2En, rs2Addr;
    logic [31:0] csrValid, csrRd, csrData;
    logic [31:0] aluValid, aluRd, aluData;
    logic [31:0] fpuValid, fpuRd, fpuData;
    logic [31:0] expStall, expAluReady, expFpuReady, expWen;
    logic [31:0] expWaddr, expWdata, expCount, expBusy;
    string       name;
  } vec_t;

  localparam int NVEC = 21;

  logic clk = 1'b0;
  logic rst_l;
  int   nChecks = 0;
  int   nFails  = 0;
  int   popped  = 0;
  logic [31:0] model[$];
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  int_wb_scoreboard_if #(.XLEN(32), .NREG(32), .QDEPTH(4)) bus ();

  int_wb_scoreboard #(.XLEN(32), .NREG(32), .QDEPTH(4), .STARVE_MAX(3)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    bus.issue_valid = 1'b0; bus.issue_fpu = 1'b0; bus.issue_rd = '0;
    bus.rs1_en = 1'b0; bus.rs1_addr = '0; bus.rs2_en = 1'b0; bus.rs2_addr = '0;
    bus.csr_valid = 1'b0; bus.csr_rd = '0; bus.csr_data = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.fpu_valid = 1'b0; bus.fpu_rd = '0; bus.fpu_data = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.issue_valid = v.issueValid[0]; bus.issue_fpu = v.issueFpu[0];
    bus.issue_rd    = v.issueRd[4:0];
    bus.rs1_en = v.rs1En[0]; bus.rs1_addr = v.rs1Addr[4:0];
    bus.rs2_en = v.rs2En[0]; bus.rs2_addr = v.rs2Addr[4:0];
    bus.csr_valid = v.csrValid[0]; bus.csr_rd = v.csrRd[4:0]; bus.csr_data = v.csrData;
    bus.alu_valid = v.aluValid[0]; bus.alu_rd = v.aluRd[4:0]; bus.alu_data = v.aluData;
    bus.fpu_valid = v.fpuValid[0]; bus.fpu_rd = v.fpuRd[4:0]; bus.fpu_data = v.fpuData;
  endtask

  // FIFO entries in the full/wrap sequence all target x12; check their order.
  task automatic scanWrites();
    if (bus.wb_wen && bus.wb_waddr == 5'd12) begin
      nChecks++;
      if (model.size() == 0) begin
        nFails++;
        $display("[TB] FAIL fifoOrder: got unexpected write 0x%0h, expected none", bus.wb_wdata);
      end else begin
        nChecks--;
        checkOutput($sformatf("fifoOrder%0d", popped), bus.wb_wdata, model.pop_front());
      end
      popped++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  pushIdx;
    logic drained;

    //            iv ifp ird r1e r1a r2e r2a  cv crd cdat          av ard adat          fv frd fdat          st ar fr wen wa wdata        cnt bsy
    vecs[0]  = '{0,0,0, 0,0,0,0, 0,0,0,            0,0,0,            0,0,0,            0,0,1,0,0,0,            0,0, "idle"};
    vecs[1]  = '{1,1,5, 0,0,0,0, 0,0,0,            0,0,0,            0,0,0,            0,0,1,0,0,0,            0,0, "issueFpu5"};
    vecs[2]  = '{1,0,6, 1,5,0,0, 0,0,0,            0,0,0,            1,5,'hAAAA0005,   1,0,1,0,0,0,            0,1, "rawStall"};
    vecs[3]  = '{1,0,6, 1,5,0,0, 0,0,0,            0,0,0,            0,0,0,            1,0,1,0,0,0,            1,1, "rawHold"};
    vecs[4]  = '{1,0,6, 1,5,0,0, 0,0,0,            0,0,0,            0,0,0,            0,0,1,1,5,'hAAAA0005,   0,0, "rawFree"};
    vecs[5]  = '{0,0,0, 0,0,0,0, 0,0,0,            0,0,0,            1,7,'h77,         0,0,1,0,0,0,            0,0, "pushPrio"};
    vecs[6]  = '{0,0,0, 0,0,0,0, 1,1,'hC5C50001,   1,2,'hA1A10002,   0,0,0,            0,0,1,0,0,0,            1,0, "prioAll"};
    vecs[7]  = '{0,0,0, 0,0,0,0, 0,0,0,            1,2,'hA1A10002,   0,0,0,            0,1,1,1,1,'hC5C50001,   1,0, "prioAlu"};
    vecs[8]  = '{0,0,0, 0,0,0,0, 0,0,0,            0,0,0,            0,0,0,            0,0,1,1,2,'hA1A10002,   1,0, "prioHead"};
    vecs[9]  = '{0,0,0, 0,0,0,0, 0,0,0,            0,0,0,            0,0,0,            0,0,1,1,7,'h77,         0,0, "prioDone"};
    vecs[10] = '{0,0,0, 0,0,0,0, 0,0,0,            1,0,'hBEEF0000,   1,0,'hDEAD0000,   0,1,1,0,0,0,            0,0, "x0Push"};
    vecs[11] = '{0,0,0, 0,0,0,0, 0,0,0,            0,0,0,            0,0,0,            0,0,1,0,0,0,            1,0, "x0Head"};
    vecs[12] = '{1,1,0, 0,0,0,0, 0,0,0,            0,0,0,            0,0,0,            0,0,1,0,0,0,            0,0, "x0Issue"};
    vecs[13] = '{0,0,0, 0,0,0,0, 0,0,0,            0,0,0,            0,0,0,            0,0,1,0,0,0,            0,0, "x0NoPend"};
    vecs[14] = '{1,1,9, 0,0,0,0, 0,0,0,            0,0,0,            0,0,0,            0,0,1,0,0,0,            0,0, "wawSet"};
    vecs[15] = '{1,0,9, 0,0,0,0, 0,0,0,            0,0,0,            0,0,0,            1,0,1,0,0,0,            0,1, "wawStall"};
    vecs[16] = '{1,0,3, 0,0,1,9, 0,0,0,            0,0,0,            0,0,0,            1,0,1,0,0,0,            0,1, "rs2Stall"};
    vecs[17] = '{1,0,3, 0,9,0,9, 0,0,0,            0,0,0,            0,0,0,            0,0,1,0,0,0,            0,1, "rsDisabled"};
    vecs[18] = '{0,0,0, 0,0,0,0, 0,0,0,            0,0,0,            1,9,'h99,         0,0,1,0,0,0,            0,1, "fpuRes9"};
    vecs[19] = '{0,0,0, 0,0,0,0, 0,0,0,            0,0,0,            0,0,0,            0,0,1,0,0,0,            1,1, "head9"};
    vecs[20] = '{0,0,0, 0,0,0,0, 0,0,0,            0,0,0,            0,0,0,            0,0,1,1,9,'h99,         0,0, "clear9"};

    rst_l = 1'b0;
    clearInputs();
    @(negedge clk);
    #1;
    checkOutput("resetWen",      32'(bus.wb_wen),     32'd0);
    checkOutput("resetCount",    32'(bus.fifo_count), 32'd0);
    checkOutput("resetBusy",     32'(bus.busy),       32'd0);
    checkOutput("resetFpuReady", 32'(bus.fpu_ready),  32'd0);
    rst_l = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput({vecs[i].name, ".stall"},     32'(bus.stall),      vecs[i].expStall);
      checkOutput({vecs[i].name, ".aluReady"},  32'(bus.alu_ready),  vecs[i].expAluReady);
      checkOutput({vecs[i].name, ".fpuReady"},  32'(bus.fpu_ready),  vecs[i].expFpuReady);
      checkOutput({vecs[i].name, ".wbWen"},     32'(bus.wb_wen),     vecs[i].expWen);
      checkOutput({vecs[i].name, ".wbWaddr"},   32'(bus.wb_waddr),   vecs[i].expWaddr);
      checkOutput({vecs[i].name, ".wbWdata"},   bus.wb_wdata,        vecs[i].expWdata);
      checkOutput({vecs[i].name, ".fifoCount"}, 32'(bus.fifo_count), vecs[i].expCount);
      checkOutput({vecs[i].name, ".busy"},      32'(bus.busy),       vecs[i].expBusy);
      @(negedge clk);
    end

    // Starvation: one queued entry loses three times to a persistent ALU.
    clearInputs();
    bus.fpu_valid = 1'b1; bus.fpu_rd = 5'd10; bus.fpu_data = 32'h0000_1010;
    @(negedge clk);
    clearInputs();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd11;
    for (int k = 0; k < 4; k++) begin
      bus.alu_data = 32'h0000_1100 + 32'(k);
      #1;
      checkOutput($sformatf("starveAluReady%0d", k), 32'(bus.alu_ready), (k < 3) ? 32'd1 : 32'd0);
      if (k == 3) begin
        checkOutput("starveAluWaddr", 32'(bus.wb_waddr), 32'd11);
        checkOutput("starveAluWdata", bus.wb_wdata, 32'h0000_1102);
      end
      @(negedge clk);
    end
    bus.alu_valid = 1'b0;
    #1;
    checkOutput("starveHeadWen",   32'(bus.wb_wen),   32'd1);
    checkOutput("starveHeadWaddr", 32'(bus.wb_waddr), 32'd10);
    checkOutput("starveHeadWdata", bus.wb_wdata,      32'h0000_1010);
    @(negedge clk);

    // FIFO fill behind the ALU, full back-pressure, then push+pop and wrap.
    for (int c = 0; c < 4; c++) begin
      clearInputs();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h0000_2000 + 32'(c);
      bus.fpu_valid = 1'b1; bus.fpu_rd = 5'd12; bus.fpu_data = 32'hF000_0000 + 32'(c);
      #1;
      checkOutput($sformatf("fillReady%0d", c), 32'(bus.fpu_ready), 32'd1);
      model.push_back(32'hF000_0000 + 32'(c));
      scanWrites();
      @(negedge clk);
    end
    bus.fpu_data = 32'h0000_0BAD;
    #1;
    checkOutput("fullFpuReady", 32'(bus.fpu_ready),  32'd0);
    checkOutput("fullCount",    32'(bus.fifo_count), 32'd4);
    checkOutput("fullAluReady", 32'(bus.alu_ready),  32'd0);
    scanWrites();
    @(negedge clk);

    pushIdx = 4;
    while (pushIdx < 10) begin
      clearInputs();
      bus.fpu_valid = 1'b1; bus.fpu_rd = 5'd12; bus.fpu_data = 32'hF000_0000 + 32'(pushIdx);
      #1;
      checkOutput($sformatf("pushPopCount%0d", pushIdx), 32'(bus.fifo_count), 32'd3);
      checkOutput($sformatf("pushPopReady%0d", pushIdx), 32'(bus.fpu_ready),  32'd1);
      model.push_back(32'hF000_0000 + 32'(pushIdx));
      scanWrites();
      pushIdx++;
      @(negedge clk);
    end

    drained = 1'b0;
    clearInputs();
    for (int i = 0; i < 20; i++) begin
      #1;
      scanWrites();
      if (bus.fifo_count == '0 && !bus.wb_wen) begin
        drained = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("drainDone", 32'(drained), 32'd1);
    checkOutput("popCount",  32'(popped),  32'd10);
    @(negedge clk);

    // Reset mid-operation: three queued entries and x5/x10 pending.
    clearInputs();
    bus.issue_valid = 1'b1; bus.issue_fpu = 1'b1; bus.issue_rd = 5'd5;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h0000_3000;
    bus.fpu_valid = 1'b1; bus.fpu_rd = 5'd5; bus.fpu_data = 32'h0000_0055;
    @(negedge clk);
    bus.issue_rd = 5'd10; bus.fpu_rd = 5'd10;
    @(negedge clk);
    bus.issue_valid = 1'b0; bus.issue_fpu = 1'b0; bus.fpu_rd = 5'd5;
    @(negedge clk);
    bus.fpu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.rs1_en = 1'b1; bus.rs1_addr = 5'd10;
    #1;
    checkOutput("midCount", 32'(bus.fifo_count), 32'd3);
    checkOutput("midBusy",  32'(bus.busy),       32'd1);
    checkOutput("midStall", 32'(bus.stall),      32'd1);
    checkOutput("midWen",   32'(bus.wb_wen),     32'd1);
    #1;
    rst_l = 1'b0;
    #1;
    checkOutput("rstCount",    32'(bus.fifo_count), 32'd0);
    checkOutput("rstBusy",     32'(bus.busy),       32'd0);
    checkOutput("rstWen",      32'(bus.wb_wen),     32'd0);
    checkOutput("rstWaddr",    32'(bus.wb_waddr),   32'd0);
    checkOutput("rstWdata",    bus.wb_wdata,        32'd0);
    checkOutput("rstFpuReady", 32'(bus.fpu_ready),  32'd0);
    checkOutput("rstAluReady", 32'(bus.alu_ready),  32'd0);
    checkOutput("rstStall",    32'(bus.stall),      32'd0);
    clearInputs();
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    #1;
    checkOutput("relFpuReady", 32'(bus.fpu_ready),  32'd1);
    checkOutput("relCount",    32'(bus.fifo_count), 32'd0);
    checkOutput("relBusy",     32'(bus.busy),       32'd0);
    @(negedge clk);
    #1;
    checkOutput("relNoStaleWen", 32'(bus.wb_wen),   32'd0);
    checkOutput("relCountStill", 32'(bus.fifo_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/int_wb_scoreboard.md
# int_wb_scoreboard

Integer-register writeback arbiter and RAW/WAW scoreboard for the FPU coprocessor front end. It sits between the decode stage and the integer register-file write port. It merges three result sources onto one registered write port: CSR read-back, scalar ALU (ADDI/LUI), and FPU integer results (compare/classify/convert/move). It also tracks integer destinations still owed by the FPU and stalls dependent instructions at decode.

## Interface
Parameters:
- XLEN, 32, data width of every result path
- NREG, 32, number of integer registers; AW = $clog2(NREG)
- QDEPTH, 4, FPU result FIFO depth (power of two, >= 2)
- STARVE_MAX, 3, consecutive lost arbitration cycles before the FIFO head outranks the ALU

Ports (clock and reset first):
- clk  in  1  clock; all state updates on rising edge
- rst_l  in  1  reset; asynchronous assertion, active-low
- issue_valid  in  1  decode presents an instruction this cycle
- issue_fpu  in  1  the issued instruction is an FPU op with an integer destination
- issue_rd  in  AW  destination register of the issued instruction
- rs1_en, rs2_en  in  1 each  source-operand read enables
- rs1_addr, rs2_addr  in  AW each  source-operand addresses
- stall  out  1  combinational hazard stall to decode
- csr_valid  in  1; csr_rd  in  AW; csr_data  in  XLEN  CSR read-back; always accepted
- alu_valid  in  1; alu_rd  in  AW; alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result granted this cycle
- fpu_valid  in  1; fpu_rd  in  AW; fpu_data  in  XLEN  FPU integer result
- fpu_ready  out  1  FIFO can accept a push
- wb_wen  out  1; wb_waddr  out  AW; wb_wdata  out  XLEN  registered register-file write port
- fifo_count  out  $clog2(QDEPTH)+1  current FIFO occupancy
- busy  out  1  OR of all pending bits

## Operation
Scoreboard:
- Pending vector pend[NREG-1:0]. Bit 0 is never set.
- Set: issue_valid & issue_fpu & ~stall & issue_rd != 0 sets pend[issue_rd].
- Clear: the FIFO-head write that drives wb_wen for rd clears pend[rd].
- Set and clear of the same bit in the same cycle: set wins.
- stall = issue_valid & ((rs1_en & pend[rs1_addr]) | (rs2_en & pend[rs2_addr]) | pend[issue_rd]).
- An issue is blocked on a WAW hazard even when it targets the ALU.

FPU FIFO:
- Push when fpu_valid & fpu_ready.
- fpu_ready = (fifo_count != QDEPTH). It depends on the current count only; a pop in the same cycle does not open a slot.
- Read and write pointers wrap modulo QDEPTH.
- A push and a pop in the same cycle leave the count unchanged.

Arbitration (one grant per cycle):
- Priority order: csr > alu > FIFO head.
- When starve_cnt == STARVE_MAX, the order becomes csr > FIFO head > alu.
- alu_ready is high only when the ALU wins the grant.
- starve_cnt increments when the FIFO is non-empty and its head loses the grant, saturating at STARVE_MAX. It resets to 0 when the head is granted or the FIFO is empty.

Write gating:
- A granted entry with rd == 0 is consumed and still clears its scoreboard bookkeeping, but wb_wen stays 0.

Reset:
- rst_l low clears pend, the FIFO pointers, fifo_count and starve_cnt immediately.
- Queued FIFO entries are discarded.
- Every output resets to 0: wb_wen, wb_waddr, wb_wdata, fifo_count, busy, alu_ready, stall.
- fpu_ready is driven 0 while in reset and goes to 1 on the first cycle after release.

## Timing
- stall, alu_ready and fpu_ready are combinational from the current inputs and state.
- Grant at edge N: wb_wen/wb_waddr/wb_wdata are valid in cycle N+1, held for one cycle only.
- CSR and ALU latency is one cycle.
- FPU minimum latency is two cycles: push at edge N, head granted in cycle N+1, write visible in cycle N+2.
- A pending bit clears on the same edge that registers the write. A dependent instruction is therefore unstalled in the cycle in which wb_wen is high.

## Test plan
- Reset mid-operation: FIFO holds 3 entries and pend = 0x0000_0420; assert rst_l low → fifo_count=0, busy=0, wb_wen=0 immediately; after release fpu_ready=1.
- RAW hazard: issue FPU op with rd=5, then issue with rs1_en=1, rs1_addr=5 → stall=1 until the cycle wb_wen=1 with wb_waddr=5, then stall=0.
- Priority: csr_valid, alu_valid and a non-empty FIFO in the same cycle → CSR written first, then ALU, then FIFO head in consecutive cycles.
- Starvation: keep alu_valid high continuously with 1 FIFO entry and STARVE_MAX=3 → after 3 lost cycles the FIFO head is granted and alu_ready=0 for that cycle.
- FIFO full: push 4 entries while the ALU holds the port → fpu_ready=0 at count 4; push and pop in the same cycle keep the count unchanged; pointers wrap correctly over 10 entries with data order preserved.
- x0 handling: fpu_rd=0 and alu_rd=0 results → consumed, wb_wen never asserts, busy stays 0.
